rs_frame_ctrl: RTL

Frame sequencer for the RS encoder datapath (`RS_top`, 8-bit symbols). It accepts message symbols over a valid/ready stream and drives the encoder's clear, enable and parity-shift controls. It emits a systematic codeword stream of K message symbols followed by NPAR parity symbols, with start-of-packet and end-of-packet markers. It sits between the symbol source and the channel/output stage, and it is the only block that sequences the encoder.

---
 rtl/rs_frame_ctrl_if.sv | 24 ++
 rtl/rs_frame_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rs_frame_ctrl_if.sv
// Stream bundle of the RS frame sequencer: message symbols in (s_*),
// systematic codeword symbols out (c_*).
interface rs_frame_ctrl_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       c_ready;
    logic [7:0] c_data;
    logic       c_valid;
    logic       c_sop;
    logic       c_eop;

    // Environment side: sources message symbols and sinks codeword symbols.
    modport master (
        output s_data, s_valid, c_ready,
        input  s_ready, c_data, c_valid, c_sop, c_eop
    );

    // Controller side.
    modport slave (
        input  s_data, s_valid, c_ready,
        output s_ready, c_data, c_valid, c_sop, c_eop
    );
endinterface

// File: rtl/rs_frame_ctrl.sv
// Frame sequencer for the RS encoder datapath. Passes K message symbols
// straight through to the codeword stream while the encoder absorbs them,
// then streams NPAR parity symbols out of the encoder, with one encoder
// clear cycle between frames.
module rs_frame_ctrl #(
    parameter int K    = 239,
    parameter int NPAR = 16
) (
    input  logic           clk,
    input  logic           rst,
    rs_frame_ctrl_if.slave stream,
    output logic           o_enc_clr,
    output logic           o_enc_en,
    output logic           o_enc_shift,
    output logic [7:0]     o_enc_m,
    input  logic [7:0]     i_enc_par,
    output logic           o_busy,
    output logic [15:0]    o_frame_cnt
);
    localparam int MAX_CNT = (K > NPAR) ? K : NPAR;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(NPAR - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_sym_cnt;
    logic [CNT_W-1:0] w_sym_cnt_nxt;
    logic [15:0]      r_frame_cnt;
    logic [15:0]      w_frame_cnt_nxt;

    logic             w_s_ready;
    logic             w_c_valid;
    logic [7:0]       w_c_data;
    logic             w_c_sop;
    logic             w_c_eop;
    logic             w_enc_clr;
    logic             w_enc_en;
    logic             w_enc_shift;
    logic [7:0]       w_enc_m;
    logic             w_busy;
    logic             w_s_hs;

    // State register: phase, symbol position within the phase, completed frames.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sym_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sym_cnt   <= w_sym_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // In MSG the source is accepted exactly when the sink accepts.
    assign w_s_hs = stream.s_valid & stream.c_ready;

    // Next-state and output decode for the three frame phases.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave a signal unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_sym_cnt_nxt   = r_sym_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_s_ready       = 1'b0;
        w_c_valid       = 1'b0;
        w_c_data        = 8'h00;
        w_c_sop         = 1'b0;
        w_c_eop         = 1'b0;
        w_enc_clr       = 1'b0;
        w_enc_en        = 1'b0;
        w_enc_shift     = 1'b0;
        w_enc_m         = 8'h00;
        w_busy          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // One clear cycle per frame, then straight into the message.
                w_enc_clr     = 1'b1;
                w_state_nxt   = ST_MSG;
                w_sym_cnt_nxt = '0;
            end

            ST_MSG: begin
                w_busy    = 1'b1;
                w_s_ready = stream.c_ready;
                w_c_valid = stream.s_valid;
                w_c_data  = stream.s_data;
                w_enc_m   = stream.s_data;
                w_enc_en  = w_s_hs;
                w_c_sop   = stream.s_valid && (r_sym_cnt == '0);
                if (w_s_hs) begin
                    if (r_sym_cnt == K_LAST) begin
                        w_state_nxt   = ST_PAR;
                        w_sym_cnt_nxt = '0;
                    end else begin
                        w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
                    end
                end
            end

            ST_PAR: begin
                // Parity is always available; the sink alone paces the shift.
                w_busy      = 1'b1;
                w_c_valid   = 1'b1;
                w_c_data    = i_enc_par;
                w_enc_shift = stream.c_ready;
                w_c_eop     = (r_sym_cnt == P_LAST);
                if (stream.c_ready) begin
                    if (r_sym_cnt == P_LAST) begin
                        w_state_nxt     = ST_IDLE;
                        w_sym_cnt_nxt   = '0;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    end else begin
                        w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_sym_cnt_nxt = '0;
            end
        endcase
    end

    assign stream.s_ready = w_s_ready;
    assign stream.c_valid = w_c_valid;
    assign stream.c_data  = w_c_data;
    assign stream.c_sop   = w_c_sop;
    assign stream.c_eop   = w_c_eop;
    assign o_enc_clr      = w_enc_clr;
    assign o_enc_en       = w_enc_en;
    assign o_enc_shift    = w_enc_shift;
    assign o_enc_m        = w_enc_m;
    assign o_busy         = w_busy;
    assign o_frame_cnt    = r_frame_cnt;
endmodule
